// File: rtl/gps_gen_sequencer.sv
// Epoch/bit sequencer for the GPS signal generator: latches the satellite setup,
// primes the C/A generator and frames nav data bits into words and subframes.
module gps_gen_sequencer #(
  parameter int EPOCHS_PER_BIT     = 20,
  parameter int BITS_PER_WORD      = 30,
  parameter int WORDS_PER_SUBFRAME = 10,
  parameter int CA_PHASE_W         = 10,
  parameter int DOPPLER_W          = 16,
  parameter int N_SAT_W            = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic [N_SAT_W-1:0]    n_sat_in,
  input  logic [CA_PHASE_W-1:0] ca_phase_in,
  input  logic [DOPPLER_W-1:0]  doppler_in,
  input  logic                  use_msg_preset_in,
  input  logic                  code_phase_done_in,
  input  logic                  msg_bit_in,
  input  logic                  msg_valid_in,
  output logic                  msg_ready_out,
  output logic                  ca_load_out,
  output logic [N_SAT_W-1:0]    n_sat_out,
  output logic [CA_PHASE_W-1:0] ca_phase_out,
  output logic [DOPPLER_W-1:0]  doppler_out,
  output logic                  nco_en_out,
  output logic                  data_bit_out,
  output logic                  bit_strobe_out,
  output logic                  word_strobe_out,
  output logic                  subframe_strobe_out,
  output logic                  underrun_out
);

  localparam int EPOCH_W = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
  localparam int BIT_W   = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int WORD_W  = (WORDS_PER_SUBFRAME > 1) ? $clog2(WORDS_PER_SUBFRAME) : 1;
  localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(EPOCHS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(WORDS_PER_SUBFRAME - 1);
  localparam logic [7:0]         PREAMBLE   = 8'b1000_1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PRIME = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [EPOCH_W-1:0]  epoch_cnt_r, epoch_cnt_s;
  logic [BIT_W-1:0]    bit_cnt_r, bit_cnt_s;
  logic [WORD_W-1:0]   word_cnt_r, word_cnt_s;
  logic                buf_full_r, buf_full_s;
  logic                buf_bit_r, buf_bit_s;
  logic                preset_r, preset_s;
  logic [2:0]          preset_idx_r, preset_idx_s;

  logic                  msg_ready_s, ca_load_s, nco_en_s, data_bit_s, underrun_s;
  logic                  bit_strobe_s, word_strobe_s, subframe_strobe_s;
  logic [N_SAT_W-1:0]    n_sat_s;
  logic [CA_PHASE_W-1:0] ca_phase_s;
  logic [DOPPLER_W-1:0]  doppler_s;

  logic transfer_s, consume_s, have_bit_s, head_bit_s;

  // In preset mode the buffer is never empty; the head bit walks the preamble MSB first.
  assign transfer_s = msg_valid_in & msg_ready_out;
  assign have_bit_s = preset_r | buf_full_r;
  assign head_bit_s = preset_r ? PREAMBLE[3'd7 - preset_idx_r] : buf_bit_r;

  // Next-state, counter, buffer and output computation.
  always_comb begin
    state_s           = state_r;
    epoch_cnt_s       = epoch_cnt_r;
    bit_cnt_s         = bit_cnt_r;
    word_cnt_s        = word_cnt_r;
    buf_full_s        = buf_full_r;
    buf_bit_s         = buf_bit_r;
    preset_s          = preset_r;
    preset_idx_s      = preset_idx_r;
    ca_load_s         = 1'b0;
    n_sat_s           = n_sat_out;
    ca_phase_s        = ca_phase_out;
    doppler_s         = doppler_out;
    nco_en_s          = nco_en_out;
    data_bit_s        = data_bit_out;
    bit_strobe_s      = 1'b0;
    word_strobe_s     = 1'b0;
    subframe_strobe_s = 1'b0;
    underrun_s        = underrun_out;
    consume_s         = 1'b0;

    if (!enable_in) begin
      state_s      = IDLE;
      epoch_cnt_s  = '0;
      bit_cnt_s    = '0;
      word_cnt_s   = '0;
      buf_full_s   = 1'b0;
      buf_bit_s    = 1'b0;
      preset_idx_s = 3'd0;
      nco_en_s     = 1'b0;
      data_bit_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s      = LOAD;
          ca_load_s    = 1'b1;
          n_sat_s      = n_sat_in;
          ca_phase_s   = ca_phase_in;
          doppler_s    = doppler_in;
          underrun_s   = 1'b0;
          epoch_cnt_s  = '0;
          bit_cnt_s    = '0;
          word_cnt_s   = '0;
          preset_idx_s = 3'd0;
          preset_s     = use_msg_preset_in;
          buf_full_s   = 1'b0;
        end
        LOAD: state_s = PRIME;
        PRIME: begin
          if (have_bit_s) begin
            consume_s         = 1'b1;
            data_bit_s        = head_bit_s;
            bit_strobe_s      = 1'b1;
            word_strobe_s     = 1'b1;
            subframe_strobe_s = 1'b1;
            nco_en_s          = 1'b1;
            state_s           = RUN;
          end else begin
            state_s = PRIME;
          end
        end
        RUN: begin
          if (code_phase_done_in && (epoch_cnt_r == EPOCH_LAST)) begin
            epoch_cnt_s  = '0;
            bit_strobe_s = 1'b1;
            doppler_s    = doppler_in;
            if (have_bit_s) begin
              consume_s  = 1'b1;
              data_bit_s = head_bit_s;
            end else begin
              data_bit_s = 1'b0;
              underrun_s = 1'b1;
            end
            if (bit_cnt_r == BIT_LAST) begin
              bit_cnt_s  = '0;
              word_cnt_s = (word_cnt_r == WORD_LAST) ? '0 : word_cnt_r + 1'b1;
            end else begin
              bit_cnt_s = bit_cnt_r + 1'b1;
            end
            word_strobe_s     = (bit_cnt_s == '0);
            subframe_strobe_s = (bit_cnt_s == '0) && (word_cnt_s == '0);
          end else if (code_phase_done_in) begin
            epoch_cnt_s = epoch_cnt_r + 1'b1;
          end else begin
            epoch_cnt_s = epoch_cnt_r;
          end
        end
        default: state_s = IDLE;
      endcase

      // A same-cycle transfer lands after the consume, so it refills for the next boundary.
      if (consume_s && preset_r) begin
        preset_idx_s = preset_idx_r + 3'd1;
      end else if (consume_s) begin
        buf_full_s = 1'b0;
      end else begin
        preset_idx_s = preset_idx_s;
      end
      if (transfer_s) begin
        buf_full_s = 1'b1;
        buf_bit_s  = msg_bit_in;
      end else begin
        buf_bit_s = buf_bit_s;
      end
    end

    msg_ready_s = ((state_s == PRIME) || (state_s == RUN)) && !preset_s && !buf_full_s;
  end

  // State, counters, buffer and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r             <= IDLE;
      epoch_cnt_r         <= '0;
      bit_cnt_r           <= '0;
      word_cnt_r          <= '0;
      buf_full_r          <= 1'b0;
      buf_bit_r           <= 1'b0;
      preset_r            <= 1'b0;
      preset_idx_r        <= 3'd0;
      msg_ready_out       <= 1'b0;
      ca_load_out         <= 1'b0;
      n_sat_out           <= '0;
      ca_phase_out        <= '0;
      doppler_out         <= '0;
      nco_en_out          <= 1'b0;
      data_bit_out        <= 1'b0;
      bit_strobe_out      <= 1'b0;
      word_strobe_out     <= 1'b0;
      subframe_strobe_out <= 1'b0;
      underrun_out        <= 1'b0;
    end else begin
      state_r             <= state_s;
      epoch_cnt_r         <= epoch_cnt_s;
      bit_cnt_r           <= bit_cnt_s;
      word_cnt_r          <= word_cnt_s;
      buf_full_r          <= buf_full_s;
      buf_bit_r           <= buf_bit_s;
      preset_r            <= preset_s;
      preset_idx_r        <= preset_idx_s;
      msg_ready_out       <= msg_ready_s;
      ca_load_out         <= ca_load_s;
      n_sat_out           <= n_sat_s;
      ca_phase_out        <= ca_phase_s;
      doppler_out         <= doppler_s;
      nco_en_out          <= nco_en_s;
      data_bit_out        <= data_bit_s;
      bit_strobe_out      <= bit_strobe_s;
      word_strobe_out     <= word_strobe_s;
      subframe_strobe_out <= subframe_strobe_s;
      underrun_out        <= underrun_s;
    end
  end

endmodule

// File: tb/tb_gps_gen_sequencer.sv
// Bench for gps_gen_sequencer: a default-size and a small-framing instance share
// stimulus and are compared every cycle against a bit-count based reference model.
module tb_gps_gen_sequencer;

  localparam int P_IDLE = 0, P_LOAD = 1, P_PRIME = 2, P_RUN = 3;
  localparam logic [7:0] PREAMBLE = 8'b1000_1011;

  logic clk = 1'b0;
  logic rst, enable, use_preset, cpd, msg_bit, msg_valid;
  logic [4:0]  n_sat;
  logic [9:0]  ca_phase;
  logic [15:0] doppler;

  logic a_ready, a_load, a_nco, a_data, a_bs, a_ws, a_sfs, a_unr;
  logic b_ready, b_load, b_nco, b_data, b_bs, b_ws, b_sfs, b_unr;
  logic [4:0]  a_nsat, b_nsat;
  logic [9:0]  a_phase, b_phase;
  logic [15:0] a_dop, b_dop;
  logic [38:0] act_a, act_b;

  assign act_a = {a_ready, a_load, a_nsat, a_phase, a_dop, a_nco, a_data, a_bs, a_ws, a_sfs, a_unr};
  assign act_b = {b_ready, b_load, b_nsat, b_phase, b_dop, b_nco, b_data, b_bs, b_ws, b_sfs, b_unr};

  always #5 clk = ~clk;

  gps_gen_sequencer dut_a (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .n_sat_in(n_sat),
    .ca_phase_in(ca_phase), .doppler_in(doppler), .use_msg_preset_in(use_preset),
    .code_phase_done_in(cpd), .msg_bit_in(msg_bit), .msg_valid_in(msg_valid),
    .msg_ready_out(a_ready), .ca_load_out(a_load), .n_sat_out(a_nsat),
    .ca_phase_out(a_phase), .doppler_out(a_dop), .nco_en_out(a_nco),
    .data_bit_out(a_data), .bit_strobe_out(a_bs), .word_strobe_out(a_ws),
    .subframe_strobe_out(a_sfs), .underrun_out(a_unr)
  );

  gps_gen_sequencer #(.EPOCHS_PER_BIT(2), .BITS_PER_WORD(3), .WORDS_PER_SUBFRAME(2)) dut_b (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .n_sat_in(n_sat),
    .ca_phase_in(ca_phase), .doppler_in(doppler), .use_msg_preset_in(use_preset),
    .code_phase_done_in(cpd), .msg_bit_in(msg_bit), .msg_valid_in(msg_valid),
    .msg_ready_out(b_ready), .ca_load_out(b_load), .n_sat_out(b_nsat),
    .ca_phase_out(b_phase), .doppler_out(b_dop), .nco_en_out(b_nco),
    .data_bit_out(b_data), .bit_strobe_out(b_bs), .word_strobe_out(b_ws),
    .subframe_strobe_out(b_sfs), .underrun_out(b_unr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sent = 0;

  // Reference model state, index 0 = default instance, 1 = small-framing instance.
  int epb [2] = '{20, 2};
  int bpw [2] = '{30, 3};
  int wps [2] = '{10, 2};
  int m_phase [2];
  int m_epoch [2];
  int m_k [2];
  logic m_pre [2];
  logic q_full [2];
  logic q_bit [2];
  logic e_ready [2], e_load [2], e_nco [2], e_data [2], e_bs [2], e_ws [2], e_sfs [2], e_unr [2];
  logic [4:0]  e_nsat [2];
  logic [9:0]  e_phase [2];
  logic [15:0] e_dop [2];

  logic got [$];
  logic gotu [$];
  logic [15:0] gotd [$];
  int wq [$];
  int sq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] exp_vec(input int i);
    return {e_ready[i], e_load[i], e_nsat[i], e_phase[i], e_dop[i],
            e_nco[i], e_data[i], e_bs[i], e_ws[i], e_sfs[i], e_unr[i]};
  endfunction

  task automatic model_reset(input int i);
    m_phase[i] = P_IDLE; m_epoch[i] = 0; m_k[i] = 0;
    m_pre[i] = 1'b0; q_full[i] = 1'b0; q_bit[i] = 1'b0;
    e_ready[i] = 1'b0; e_load[i] = 1'b0; e_nco[i] = 1'b0; e_data[i] = 1'b0;
    e_bs[i] = 1'b0; e_ws[i] = 1'b0; e_sfs[i] = 1'b0; e_unr[i] = 1'b0;
    e_nsat[i] = 5'd0; e_phase[i] = 10'd0; e_dop[i] = 16'd0;
  endtask

  // Emit bit number k of the frame: framing strobes follow from k alone.
  task automatic emit(input int i);
    logic [7:0] pre_v;
    logic b;
    pre_v = PREAMBLE;
    if (m_pre[i]) begin
      b = pre_v[7 - (m_k[i] % 8)];
    end else if (q_full[i]) begin
      b = q_bit[i];
      q_full[i] = 1'b0;
    end else begin
      b = 1'b0;
      e_unr[i] = 1'b1;
    end
    e_data[i] = b;
    e_bs[i] = 1'b1;
    e_ws[i] = ((m_k[i] % bpw[i]) == 0);
    e_sfs[i] = ((m_k[i] % (bpw[i] * wps[i])) == 0);
    m_k[i]++;
  endtask

  task automatic model_step(input int i);
    logic xfer;
    int ph;
    xfer = msg_valid && e_ready[i];
    ph = m_phase[i];
    e_load[i] = 1'b0; e_bs[i] = 1'b0; e_ws[i] = 1'b0; e_sfs[i] = 1'b0;
    if (!enable) begin
      m_phase[i] = P_IDLE; q_full[i] = 1'b0; e_nco[i] = 1'b0; e_data[i] = 1'b0;
    end else begin
      if (ph == P_IDLE) begin
        m_phase[i] = P_LOAD; e_load[i] = 1'b1;
        e_nsat[i] = n_sat; e_phase[i] = ca_phase; e_dop[i] = doppler;
        e_unr[i] = 1'b0; m_k[i] = 0; m_epoch[i] = 0;
        m_pre[i] = use_preset; q_full[i] = 1'b0;
      end else if (ph == P_LOAD) begin
        m_phase[i] = P_PRIME;
      end else if (ph == P_PRIME) begin
        if (m_pre[i] || q_full[i]) begin
          emit(i); e_nco[i] = 1'b1; m_phase[i] = P_RUN;
        end
      end else if (cpd) begin
        m_epoch[i]++;
        if (m_epoch[i] == epb[i]) begin
          m_epoch[i] = 0; emit(i); e_dop[i] = doppler;
        end
      end
      if (xfer) begin
        q_full[i] = 1'b1; q_bit[i] = msg_bit;
      end
    end
    e_ready[i] = enable && (m_phase[i] == P_PRIME || m_phase[i] == P_RUN) && !m_pre[i] && !q_full[i];
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset(0); model_reset(1);
    end else begin
      if (msg_valid && e_ready[0] && enable) sent++;
      model_step(0); model_step(1);
    end
    #1;
    chk("outputs_a", 64'(act_a), 64'(exp_vec(0)));
    chk("outputs_b", 64'(act_b), 64'(exp_vec(1)));
    if (a_bs) begin
      got.push_back(a_data); gotu.push_back(a_unr); gotd.push_back(a_dop);
    end
    if (b_ws) wq.push_back(cyc);
    if (b_sfs) sq.push_back(cyc);
  endtask

  initial begin
    logic [8:0] pre_seq;
    logic [3:0] ext_seq;
    logic [2:0] src;
    logic dop_changed;
    pre_seq = 9'b1_0001_0111;
    ext_seq = 4'b1010;
    src = 3'b101;
    rst = 1'b1; enable = 1'b0; use_preset = 1'b0; cpd = 1'b0;
    msg_bit = 1'b0; msg_valid = 1'b0; n_sat = 5'd0; ca_phase = 10'd0; doppler = 16'd0;
    model_reset(0); model_reset(1);

    // Reset state
    tick();
    chk("reset_state_a", 64'(act_a), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Preset start with preamble sequence and doppler shadowing
    n_sat = 5'd3; ca_phase = 10'h155; doppler = 16'h1234; use_preset = 1'b1; enable = 1'b1;
    got.delete(); gotd.delete();
    tick();
    chk("ca_load_pulse", 64'(a_load), 64'd1);
    chk("ca_phase_latched", 64'(a_phase), 64'h155);
    tick();
    chk("ca_load_single", 64'(a_load), 64'd0);
    chk("nco_off_in_prime", 64'(a_nco), 64'd0);
    tick();
    chk("first_bit_strobes", 64'({a_nco, a_data, a_bs, a_ws, a_sfs}), 64'h1f);
    dop_changed = 1'b0;
    for (int n = 0; n < 2000 && got.size() < 9; n++) begin
      cpd = 1'($urandom_range(0, 1));
      if (!dop_changed && got.size() == 3) begin
        doppler = 16'hABCD;
        dop_changed = 1'b1;
        tick();
        chk("doppler_held_mid_bit", 64'(a_dop), 64'h1234);
      end else begin
        tick();
      end
    end
    chk("preset_bit_count", 64'(got.size()), 64'd9);
    for (int k = 0; k < got.size(); k++) chk("preset_bit", 64'(got[k]), 64'(pre_seq[8 - k]));
    chk("doppler_before_edge", 64'(gotd[2]), 64'h1234);
    chk("doppler_at_edge", 64'(gotd[3]), 64'hABCD);

    // Framing wrap on the small instance with a C/A period every cycle
    cpd = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    wq.delete(); sq.delete();
    for (int n = 0; n < 50; n++) tick();
    chk("word_strobe_seen", 64'(wq.size() >= 8), 64'd1);
    chk("subframe_strobe_seen", 64'(sq.size() >= 4), 64'd1);
    for (int k = 1; k < wq.size(); k++) chk("word_strobe_period", 64'(wq[k] - wq[k-1]), 64'd6);
    for (int k = 1; k < sq.size(); k++) chk("subframe_strobe_period", 64'(sq[k] - sq[k-1]), 64'd12);

    // Asynchronous reset mid-run
    rst = 1'b1;
    #2;
    chk("async_reset_a", 64'(act_a), 64'd0);
    chk("async_reset_b", 64'(act_b), 64'd0);
    enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 64'(act_a), 64'd0);

    // External source: bits 1,0,1 then a withheld bit
    use_preset = 1'b0; n_sat = 5'd9; doppler = 16'($urandom); enable = 1'b1;
    got.delete(); gotu.delete(); sent = 0;
    for (int n = 0; n < 4000 && got.size() < 4; n++) begin
      cpd = 1'($urandom_range(0, 1));
      msg_valid = (sent < 3) && ($urandom_range(0, 3) != 0);
      msg_bit = msg_valid ? src[2 - sent] : 1'($urandom_range(0, 1));
      tick();
    end
    msg_valid = 1'b0;
    chk("ext_bit_count", 64'(got.size()), 64'd4);
    for (int k = 0; k < got.size(); k++) chk("ext_bit", 64'(got[k]), 64'(ext_seq[3 - k]));
    chk("no_underrun_when_fed", 64'(gotu[2]), 64'd0);
    chk("underrun_on_empty", 64'(gotu[3]), 64'd1);
    for (int n = 0; n < 3000 && got.size() < 7; n++) begin
      cpd = 1'($urandom_range(0, 1));
      msg_valid = 1'($urandom_range(0, 1));
      msg_bit = 1'($urandom_range(0, 1));
      tick();
    end
    chk("sticky_bit_count", 64'(got.size()), 64'd7);
    chk("underrun_sticky", 64'(a_unr), 64'd1);

    // Disable mid-word, new PRN, re-enable
    msg_valid = 1'b0; enable = 1'b0; n_sat = 5'd17;
    tick();
    chk("disable_nco_off", 64'(a_nco), 64'd0);
    chk("disable_ready_off", 64'(a_ready), 64'd0);
    chk("disable_underrun_held", 64'(a_unr), 64'd1);
    tick();
    enable = 1'b1; use_preset = 1'b1;
    tick();
    chk("reload_pulse", 64'(a_load), 64'd1);
    chk("reload_nsat", 64'(a_nsat), 64'd17);
    chk("reload_underrun_clear", 64'(a_unr), 64'd0);
    tick();
    tick();
    chk("restart_strobes", 64'({a_bs, a_ws, a_sfs}), 64'h7);

    // Random soak
    for (int n = 0; n < 1500; n++) begin
      cpd = ($urandom_range(0, 2) != 0);
      msg_valid = 1'($urandom_range(0, 1));
      msg_bit = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) doppler = 16'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        enable = ~enable;
        use_preset = 1'($urandom_range(0, 1));
        n_sat = 5'($urandom);
        ca_phase = 10'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gps_gen_sequencer.md
# gps_gen_sequencer

Epoch/bit sequencer for the GPS signal generator. It sits between the UART register bank and the C/A code and carrier datapath. On enable it latches the satellite configuration, loads the C/A generator's start phase and starts the carrier NCO. It then counts C/A code periods (`code_phase_done`) to frame navigation data into bits, words and subframes, pulling each data bit from a message source or from an internal preamble preset.

## Interface

**Parameters**

- `EPOCHS_PER_BIT`, default 20: C/A periods per nav data bit.
- `BITS_PER_WORD`, default 30: bits per word.
- `WORDS_PER_SUBFRAME`, default 10: words per subframe.
- `CA_PHASE_W`, default 10: C/A phase width.
- `DOPPLER_W`, default 16: Doppler word width.
- `N_SAT_W`, default 5: satellite index width.

**Ports**

- `clk_in`, in, 1: system clock.
- `rst_in`, in, 1: reset, asynchronous, active-high.
- `enable_in`, in, 1: level; run while high.
- `n_sat_in`, in, `N_SAT_W`: satellite (PRN) select.
- `ca_phase_in`, in, `CA_PHASE_W`: C/A start phase.
- `doppler_in`, in, `DOPPLER_W`: Doppler word.
- `use_msg_preset_in`, in, 1: 1 = internal preamble pattern, 0 = external source.
- `code_phase_done_in`, in, 1: 1-cycle pulse at the end of each C/A period.
- `msg_bit_in`, in, 1: data bit from the message source.
- `msg_valid_in`, in, 1: source handshake valid.
- `msg_ready_out`, out, 1: source handshake ready.
- `ca_load_out`, out, 1: 1-cycle pulse that loads the C/A generator.
- `n_sat_out`, out, `N_SAT_W`: latched satellite index.
- `ca_phase_out`, out, `CA_PHASE_W`: latched C/A phase.
- `doppler_out`, out, `DOPPLER_W`: shadowed Doppler word.
- `nco_en_out`, out, 1: carrier/code NCO enable.
- `data_bit_out`, out, 1: current nav data bit.
- `bit_strobe_out`, out, 1: 1-cycle pulse when `data_bit_out` changes to a new bit.
- `word_strobe_out`, out, 1: pulse with `bit_strobe_out` on the first bit of each word.
- `subframe_strobe_out`, out, 1: pulse with `word_strobe_out` on the first word of each subframe.
- `underrun_out`, out, 1: sticky flag; a bit boundary occurred with an empty buffer.

## Operation

**General rules**

- All outputs are registered.
- Reset value of every output is 0.

**State machine: IDLE, LOAD, PRIME, RUN**

- **IDLE**: counters are 0 and the buffer is empty. Advance to LOAD when `enable_in` = 1.
- **LOAD** (1 cycle):
  - latch `n_sat_in`, `ca_phase_in` and `doppler_in` into the outputs;
  - `ca_load_out` = 1;
  - clear `underrun_out`, all counters and the preset index.
  - Next state is PRIME.
- **PRIME**: `msg_ready_out` = 1 while the buffer is empty. When the buffer is full, or in preset mode:
  - move the bit to `data_bit_out`;
  - pulse `bit_strobe_out`, `word_strobe_out` and `subframe_strobe_out`;
  - set `nco_en_out` = 1;
  - go to RUN.
- **RUN**: each `code_phase_done_in` increments `epoch_cnt`.
  - When `epoch_cnt` = `EPOCHS_PER_BIT`-1, the epoch is a bit boundary:
    - `epoch_cnt` wraps to 0;
    - the buffer bit moves to `data_bit_out`;
    - `bit_strobe_out` pulses;
    - `bit_cnt` increments, wrapping at `BITS_PER_WORD`-1. On wrap, `word_cnt` increments, wrapping at `WORDS_PER_SUBFRAME`-1.
    - `word_strobe_out` pulses when `bit_cnt` becomes 0. `subframe_strobe_out` pulses when both `bit_cnt` and `word_cnt` become 0.
    - `doppler_out` reloads from `doppler_in`. Doppler changes apply only on bit edges.
  - `n_sat_out` and `ca_phase_out` change only in LOAD. A new PRN or phase requires disabling and re-enabling.
- **enable_in = 0** in any state: go to IDLE on the next cycle. `nco_en_out`, `data_bit_out` and `msg_ready_out` become 0, the counters and buffer clear, and `underrun_out` holds its value.

**Bit buffer (1 entry)**

- `msg_ready_out` = 1 while in PRIME or RUN, external mode, and the buffer is empty.
- A transfer occurs when `msg_valid_in` and `msg_ready_out` are both 1.
- Preset mode: the buffer is always full. The bit is preamble 8'b10001011, MSB first, cyclic. The index advances on each consume.
- Underrun: a bit boundary with an empty buffer drives `data_bit_out` = 0 and sets `underrun_out`. No forwarding: a transfer in the same cycle fills the buffer for the next boundary.
- `use_msg_preset_in` is sampled in LOAD only.

**Simultaneous events**

- `code_phase_done_in` is ignored outside RUN.
- A consume and a transfer in the same cycle leave the buffer full with the new bit.

## Timing

- `enable_in` sampled high at edge N: LOAD during N+1 (`ca_load_out` = 1), PRIME from N+2.
- Preset mode: `nco_en_out`, first bit and strobes at N+3.
- External mode: PRIME exit is 1 cycle after the transfer.
- Bit boundary: `data_bit_out` and strobes update in the cycle after the `code_phase_done_in` that completes the bit.
- Nominal bit period: `EPOCHS_PER_BIT` C/A periods (20 ms).
- Asynchronous `rst_in` mid-run forces IDLE and all-zero outputs immediately.

## Test plan

1. **Reset**: assert `rst_in` mid-RUN -> all outputs 0 immediately; state IDLE after release.
2. **Preset start**: preset mode, `ca_phase_in`=10'h155, `doppler_in`=16'h1234, enable -> `ca_load_out` 1-cycle pulse with `ca_phase_out`=10'h155; `data_bit_out`=1 with all three strobes; then bits 0,0,0,1,0,1,1,1 every 20 `code_phase_done_in` pulses.
3. **External handshake and underrun**:
   - source supplies bits 1,0,1 -> sequence appears on bit edges;
   - source withholds a bit -> `data_bit_out`=0 and `underrun_out`=1 at the next boundary;
   - `underrun_out` stays set until the next LOAD.
4. **Doppler shadowing**: change `doppler_in` to 16'hABCD mid-bit -> `doppler_out` unchanged until the next bit edge.
5. **Framing wrap**: `EPOCHS_PER_BIT`=2, `BITS_PER_WORD`=3, `WORDS_PER_SUBFRAME`=2, preset mode -> `word_strobe_out` every 6 epochs, `subframe_strobe_out` every 12 epochs.
6. **Disable/re-enable**: drop `enable_in` mid-word, change `n_sat_in` to 5'd17 -> IDLE with `nco_en_out`=0 within 1 cycle. Re-enable -> new LOAD with `n_sat_out`=17 and counters restarted, shown by `subframe_strobe_out` on the first bit.
